// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Serial add/subtract engine. One 4-bit ripple adder built from full_adder
//   cells is reused across NIBBLES cycles, LSB nibble first, with a 1-bit
//   carry register linking the nibbles. Subtraction is A + ~B + 1: the
//   carry register is seeded with SUB and the B nibble is inverted.
//
//   Parameters
//     NIBBLES  operand length in nibbles (2..8), W = 4*NIBBLES
//   Ports
//     clk      clock, rising edge
//     rst      synchronous active-high reset
//     START    begin an operation (ignored while BUSY)
//     SUB      0 = A+B, 1 = A-B (sampled with START)
//     A, B     W-bit operands (sampled with START)
//     BUSY     high while an operation is in flight
//     DONE     one-cycle pulse when OUT carries a new result
//     OUT      result of the last completed operation
//   Optional (macro NIBBLE_SERIAL_CARRY_OUT_EN)
//     COUT     final carry-out (for SUB, 1 = no borrow)
//     OVF      signed overflow (carry into MSB ^ carry out of MSB)

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 START,
  input  logic                 SUB,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*NIBBLES-1:0] OUT
`ifdef NIBBLE_SERIAL_CARRY_OUT_EN
  ,
  output logic                 COUT,
  output logic                 OVF
`endif
);
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [NIBBLES-1:0][3:0] a_q, b_q, res, res_nxt;
  logic                    sub_q;
  logic                    carry;
  logic [IW-1:0]           idx;
  logic [3:0]              a_nib, b_nib, sum;
  logic [4:0]              c;
  logic                    last;

  // Operand nibble select; B is inverted for two's-complement subtract.
  assign a_nib = a_q[idx];
  assign b_nib = b_q[idx] ^ {4{sub_q}};
  assign c[0]  = carry;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (
      .a  (a_nib[i]),
      .b  (b_nib[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign last = (idx == IW'(NIBBLES - 1));

  // Result with the current nibble merged in, so the last cycle can load
  // OUT with the complete value in the same edge the final nibble lands.
  always_comb begin
    res_nxt      = res;
    res_nxt[idx] = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      OUT   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      res   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
`ifdef NIBBLE_SERIAL_CARRY_OUT_EN
      COUT  <= 1'b0;
      OVF   <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            a_q   <= A;
            b_q   <= B;
            sub_q <= SUB;
            carry <= SUB;
            idx   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_nxt;
          carry <= c[4];
          idx   <= idx + 1'b1;
          if (last) begin
            OUT   <= res_nxt;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            idx   <= '0;
            state <= IDLE;
`ifdef NIBBLE_SERIAL_CARRY_OUT_EN
            COUT  <= c[4];
            OVF   <= c[3] ^ c[4];
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl at NIBBLES=4. Stimulus pushes
// the expected result and completion cycle; a negedge monitor pops on DONE.
module tb_nibble_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst, START, SUB;
  logic [15:0] A, B, OUT;
  logic        BUSY, DONE;
`ifdef NIBBLE_SERIAL_CARRY_OUT_EN
  logic        COUT, OVF;
`endif

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .START (START),
    .SUB   (SUB),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .OUT   (OUT)
`ifdef NIBBLE_SERIAL_CARRY_OUT_EN
    ,
    .COUT  (COUT),
    .OVF   (OVF)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] out;
    logic        c;
    logic        v;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          dones = 0;
  logic [15:0] last_out;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (DONE === 1'b1) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DONE at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out", {16'h0, OUT}, {16'h0, e.out});
        chk("done_cycle", cyc, e.cyc);
`ifdef NIBBLE_SERIAL_CARRY_OUT_EN
        chk("cout", {31'h0, COUT}, {31'h0, e.c});
        chk("ovf", {31'h0, OVF}, {31'h0, e.v});
`endif
      end
    end
  end

  // Issue one operation from a negedge; completion expected 5 posedges later
  // (E0 is the next edge, DONE visible after E4).
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] eo, input logic ec, input logic ev);
    exp_t e;
    START = 1'b1; A = a; B = b; SUB = sub;
    e.out = eo; e.c = ec; e.v = ev; e.cyc = cyc + 5;
    exp_q.push_back(e);
  endtask

  // Full operation with BUSY/OUT-hold checks through the run.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] eo, input logic ec, input logic ev);
    @(negedge clk);
    launch(a, b, sub, eo, ec, ev);
    @(negedge clk);
    START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", {31'h0, BUSY}, 32'h1);
      chk("out_hold", {16'h0, OUT}, {16'h0, last_out});
      @(negedge clk);
    end
    chk("busy_end", {31'h0, BUSY}, 32'h0);
    last_out = eo;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; START = 1'b1; SUB = 1'b0; A = 16'hAAAA; B = 16'h5555;
    repeat (3) @(negedge clk);
    // Reset beats START
    chk("rst_busy", {31'h0, BUSY}, 32'h0);
    chk("rst_done", {31'h0, DONE}, 32'h0);
    chk("rst_out", {16'h0, OUT}, 32'h0);
    rst = 1'b0; START = 1'b0;
    last_out = 16'h0;

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // START during RUN is ignored; START in the DONE cycle is accepted.
    @(negedge clk);
    launch(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(negedge clk); START = 1'b0;                       // after E0
    @(negedge clk);                                     // after E1
    START = 1'b1; A = 16'hFFFF; B = 16'hFFFF; SUB = 1'b1;
    @(negedge clk); START = 1'b0;                       // after E2
    @(negedge clk);                                     // after E3
    @(negedge clk);                                     // after E4, DONE=1
    chk("done_pulse", {31'h0, DONE}, 32'h1);
    launch(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);
    @(negedge clk); START = 1'b0;
    chk("done_one_cycle", {31'h0, DONE}, 32'h0);
    chk("busy_b2b", {31'h0, BUSY}, 32'h1);
    repeat (4) @(negedge clk);
    chk("b2b_idle", {31'h0, BUSY}, 32'h0);

    // Reset at E2 aborts with no DONE and clears OUT.
    @(negedge clk);
    START = 1'b1; A = 16'h1234; B = 16'h1111; SUB = 1'b0;
    @(negedge clk); START = 1'b0;                       // after E0
    @(negedge clk); rst = 1'b1;                         // after E1
    @(negedge clk); rst = 1'b0;                         // after E2
    chk("abort_busy", {31'h0, BUSY}, 32'h0);
    chk("abort_out", {16'h0, OUT}, 32'h0);
    chk("abort_done", {31'h0, DONE}, 32'h0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", {31'h0, DONE}, 32'h0);
    last_out = 16'h0;
    run_op(16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'h0);
    chk("done_count", dones, 32'd10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
